// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
//
// Round-robin, packet-wise arbiter that merges NUM_INPUTS AXI-Stream sources
// onto one AXI-Stream output. A grant is taken in IDLE and held in PASS until
// the beat carrying tlast transfers, so packets never interleave. The data
// path is purely combinational. Each packet costs one extra arbitration cycle.
//
// Optional build macro: AXIS_PACKET_ARBITER_TDEST_EN
//   When it is defined, the block adds axis_o_tdest, which carries the source
//   index during PASS and is 0 in IDLE.
//
// Parameters
//   AXIS_BYTES  tdata width in bytes
//   NUM_INPUTS  number of input streams (2..16)
//   IDX_W       source index width (derived)
//
// Ports
//   clk            clock, rising edge
//   sresetn        synchronous active-low reset
//   axis_i_tready  per-input ready (bit n = input n)
//   axis_i_tvalid  per-input valid
//   axis_i_tlast   per-input last
//   axis_i_tdata   concatenated input data, input n at slice n
//   axis_o_tready  output ready
//   axis_o_tvalid  output valid
//   axis_o_tlast   output last
//   axis_o_tdata   output data
//   axis_o_tdest   source index (only with AXIS_PACKET_ARBITER_TDEST_EN)
//   busy           high while a grant is held
//   grant_idx      current or most recent grant

module axis_packet_arbiter #(
  parameter  int AXIS_BYTES = 1,
  parameter  int NUM_INPUTS = 4,
  localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                               clk,
  input  logic                               sresetn,
  output logic [NUM_INPUTS-1:0]              axis_i_tready,
  input  logic [NUM_INPUTS-1:0]              axis_i_tvalid,
  input  logic [NUM_INPUTS-1:0]              axis_i_tlast,
  input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                               axis_o_tready,
  output logic                               axis_o_tvalid,
  output logic                               axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]            axis_o_tdata,
`ifdef AXIS_PACKET_ARBITER_TDEST_EN
  output logic [IDX_W-1:0]                   axis_o_tdest,
`endif
  output logic                               busy,
  output logic [IDX_W-1:0]                   grant_idx
);

  localparam int DATA_W = AXIS_BYTES * 8;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [NUM_INPUTS-1:0]   upper_mask;
  logic [NUM_INPUTS-1:0]   upper_req;
  logic [IDX_W-1:0]        pick;

  // Round-robin selection. Requests above the last grant have priority. If
  // none are pending, the search wraps to the lowest valid index. Both scans
  // run from high to low, so the lowest set index is the one kept.
  always_comb begin : arb_comb
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    upper_mask = '0;
    pick       = '0;
    for (int n = 0; n < NUM_INPUTS; n++) begin
      upper_mask[n] = (IDX_W'(n) > grant_idx);
    end
    upper_req = axis_i_tvalid & upper_mask;
    for (int n = NUM_INPUTS - 1; n >= 0; n--) begin
      if (axis_i_tvalid[n]) pick = IDX_W'(n);
    end
    for (int n = NUM_INPUTS - 1; n >= 0; n--) begin
      if (upper_req[n]) pick = IDX_W'(n);
    end
  end

  // State register.
  always_ff @(posedge clk) begin : state_reg
    // NOTE: reset is sampled only on the clock edge. There is no asynchronous path, so sresetn is ordinary synchronous logic.
    if (!sresetn) begin
      // NOTE: registered state takes non-blocking assignments, so every flop samples values from before the edge.
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The grant is latched only when leaving IDLE. It then stays fixed for the
  // whole packet, even if the granted source drops tvalid partway through.
  always_ff @(posedge clk) begin : grant_reg
    if (!sresetn) begin
      grant_idx <= IDX_W'(NUM_INPUTS - 1);
    end else if (state == IDLE && |axis_i_tvalid) begin
      grant_idx <= pick;
    end
  end

  // Next-state logic.
  always_comb begin : next_state_comb
    state_next = state;
    case (state)
      IDLE:    if (|axis_i_tvalid) state_next = PASS;
      PASS:    if (axis_o_tvalid && axis_o_tready && axis_o_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. This is a zero-latency pass-through of the granted input.
  always_comb begin : out_comb
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tdata  = '0;
    axis_i_tready = '0;
    busy          = (state == PASS);
    if (state == PASS) begin
      for (int n = 0; n < NUM_INPUTS; n++) begin
        if (grant_idx == IDX_W'(n)) begin
          axis_o_tvalid    = axis_i_tvalid[n];
          axis_o_tlast     = axis_i_tlast[n];
          axis_o_tdata     = axis_i_tdata[n*DATA_W +: DATA_W];
          axis_i_tready[n] = axis_o_tready;
        end
      end
    end
  end

`ifdef AXIS_PACKET_ARBITER_TDEST_EN
  assign axis_o_tdest = (state == PASS) ? grant_idx : '0;
`endif

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
Round-robin, packet-wise arbiter sharing one AXI-Stream output between NUM_INPUTS AXI-Stream sources. A grant is held for a whole packet, from first beat to tlast, so packets never interleave. Its typical place is in front of a packet FIFO, merging several producers into one buffered stream.

Parameters:
AXIS_BYTES, 1, tdata width in bytes.
NUM_INPUTS, 4, number of requesting input streams; legal range 2..16.
IDX_W, $clog2(NUM_INPUTS), width of the source index (localparam; minimum 1).

Ports:
clk  input  1  clock, all logic on rising edge.
sresetn  input  1  synchronous active-low reset.
axis_i_tready  output  NUM_INPUTS  per-input ready; bit n belongs to input n.
axis_i_tvalid  input  NUM_INPUTS  per-input valid.
axis_i_tlast  input  NUM_INPUTS  per-input last.
axis_i_tdata  input  NUM_INPUTS*AXIS_BYTES*8  concatenated data; input n occupies bits [(n+1)*AXIS_BYTES*8-1 : n*AXIS_BYTES*8].
axis_o_tready  input  1  output ready.
axis_o_tvalid  output  1  output valid.
axis_o_tlast  output  1  output last.
axis_o_tdata  output  AXIS_BYTES*8  output data.
busy  output  1  high while a grant is held (state PASS).
grant_idx  output  IDX_W  index of the current or most recent grant.

Behaviour:
- Clock and reset: clk is the clock. sresetn is a synchronous, active-low reset.
- Reset values: state=IDLE, grant_idx=NUM_INPUTS-1 (so input 0 has first priority), busy=0.
- Combinational outputs: axis_o_tvalid=0 and axis_i_tready=0 whenever not in PASS.
- State IDLE:
  - If any axis_i_tvalid bit is set, select the first valid input searching cyclically from grant_idx+1 mod NUM_INPUTS.
  - Register the selection into grant_idx and go to PASS.
  - No handshake occurs in IDLE.
- State PASS, with g=grant_idx:
  - axis_o_tvalid=axis_i_tvalid[g], axis_o_tlast=axis_i_tlast[g], axis_o_tdata=slice g.
  - axis_i_tready[g]=axis_o_tready; all other tready bits are 0.
  - The pass-through path is purely combinational: zero added latency.
  - Leave PASS for IDLE on the cycle where axis_o_tvalid && axis_o_tready && axis_o_tlast.
  - Otherwise stay in PASS, even if input g deasserts tvalid mid-packet. The grant is never revoked mid-packet.
- Arbitration latency:
  - One cycle from request (tvalid seen in IDLE) to first possible transfer.
  - One idle cycle between consecutive packets, so peak throughput for single-beat packets is 50%.
- Fairness: with all inputs continuously valid, grants rotate 0,1,2,...,NUM_INPUTS-1,0,...
- Single-beat packets (tvalid and tlast on the first beat) are granted, transferred and released normally.
- Wrap-around: the search from grant_idx+1 wraps modulo NUM_INPUTS. This covers non-power-of-2 NUM_INPUTS; indices >= NUM_INPUTS are never produced.
- Reset mid-packet: returns immediately to IDLE with the reset values. The partial packet is truncated; upstream and downstream recovery is the system's responsibility.
- busy equals (state==PASS).
- Inputs not granted may hold tvalid indefinitely. Their tvalid/tdata are not consumed, and dropping tvalid before grant is tolerated (no request latching).

Optional Feature:
Macro: AXIS_PACKET_ARBITER_TDEST_EN.
- Defined: adds output port axis_o_tdest [IDX_W-1:0]. It equals grant_idx while in PASS and is 0 in IDLE. Downstream can then demultiplex by source.
- Undefined: the port is absent and there is no other behavioural difference.

Test Plan:
1. Reset, then input 2 presents a 3-beat packet with axis_o_tready=1 -> grant_idx=2 one cycle after tvalid; 3 output beats with matching data, tlast on beat 3; next cycle busy=0.
2. All 4 inputs continuously send 2-beat packets -> output sources in order 0,1,2,3,0,1; each packet contiguous; one gap cycle between packets.
3. Input 1 packet with tvalid dropped for 5 cycles mid-packet while input 3 is valid -> no beat from input 3 until input 1's tlast transfers; axis_i_tready[3]=0 throughout.
4. axis_o_tready toggled 1010... during a 4-beat packet -> output tdata and tlast stable while stalled; exactly 4 transfers; input tready mirrors output tready.
5. Assert sresetn=0 for one cycle at beat 2 of a 5-beat packet -> next cycle busy=0, axis_o_tvalid=0, grant_idx=NUM_INPUTS-1; a following request from input 0 wins.
6. NUM_INPUTS=3 with AXIS_PACKET_ARBITER_TDEST_EN defined, all inputs valid -> tdest sequence 0,1,2,0, never 3; tdest=0 in gap cycles.
